point_out_writeback: RTL
========================

Name: point_out_writeback

Overview:
- Downstream of the depthwise-separable unit: consumes the 8-lane pointwise output.
- Accumulates partial sums across input-channel groups of 8 (one per in_ch_sel step).
- Requantizes the accumulated sums: arithmetic shift, optional ReLU, saturation.
- Issues one 8-lane write per (pixel, output-channel group) into the next layer's feature memory, with a linear address.

Parameters:
- DATA_WIDTH, 8: signed lane width of input and output features.
- LANES, 8: output channels per beat.
- ACC_WIDTH, 20: signed accumulator width per lane.
- ADDR_WIDTH, 16: feature-memory address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_feature beat is valid this cycle.
- in_feature  in  DATA_WIDTH*LANES  signed lanes; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ch_sel  in  8  input-channel base of this beat (multiple of 8).
- out_ch_sel  in  8  output-channel base of this beat (multiple of 8).
- input_channel  in  8  layer input channels (values <8 treated as 8).
- output_channel  in  8  layer output channels (values <8 treated as 8).
- output_size  in  8  output feature width = height.
- relu_en  in  1  clamp negative results to 0.
- quant_shift  in  4  arithmetic right shift applied before saturation.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  DATA_WIDTH*LANES  requantized lanes.
- pixel_done  out  1  pulse with the last output-group write of a pixel.
- layer_done  out  1  pulse with the last write of the layer.
- seq_err  out  1  sticky sequence-error flag.

Behaviour:
- Reset values: all outputs 0; acc, pix_cnt and state cleared; state=IDLE. Reset mid-operation discards partial sums with no write.
- Derived counts: IG = max(input_channel,8)/8, OG = max(output_channel,8)/8, NPIX = output_size*output_size. Sample configuration in IDLE only; hold constant while not IDLE.
- Accumulate, on in_valid:
  - in_ch_sel==0: acc[k] <= sign-extended in_feature lane k (restart).
  - otherwise: acc[k] <= acc[k] + lane k.
  - Overflow of ACC_WIDTH wraps; this is not checked.
- FSM states: IDLE, ACCUM.
  - IDLE -> ACCUM on in_valid with in_ch_sel==0.
  - in_valid with in_ch_sel!=0 in IDLE: set seq_err, ignore the beat.
  - In ACCUM, a beat whose in_ch_sel is not the previous value+8 (and is not 0) sets seq_err; the beat is still accumulated.
  - A beat with in_ch_sel==(IG-1)*8 is the last group: capture the final sum (acc + lane) into the requant register; state -> IDLE. If IG==1, the first beat is also the last.
- Requant stage (registered):
  - v = final >>> quant_shift (arithmetic).
  - If relu_en and v<0: v=0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Write timing: wr_en=1 for exactly one cycle, 2 cycles after the last-group beat.
  - wr_addr = pix_cnt*OG + out_ch_sel_latched/8, truncated to ADDR_WIDTH. out_ch_sel is latched on the last-group beat.
- Pipelining:
  - A new group may start on the cycle immediately after a last-group beat; no stall, no ready signal.
  - Back-to-back single-beat groups (IG==1) give one write per cycle.
- Pixel counter:
  - When a write has out_ch_sel/8==OG-1, pixel_done pulses with that wr_en and pix_cnt increments after the write.
  - If pix_cnt==NPIX-1, layer_done also pulses and pix_cnt wraps to 0.
- seq_err clears only on rst.

Test Plan:
- IG=1, OG=1, output_size=2, shift=0, relu off; 4 beats, lanes {1,-2,3,-4,5,-6,7,-8} -> 4 writes at addr 0..3, each 2 cycles after its beat, data unchanged; pixel_done on every write; layer_done on the 4th write; pix_cnt returns to 0.
- input_channel=32 (IG=4); lane0 beats 100,100,100,100 with shift=2 -> wr_data lane0 = 100 (400>>>2); no write until the 4th beat.
- Saturation: IG=2, lane0 = 127+127, shift=0 -> 127. Lane1 = -128 + -128 -> -128 with relu off, 0 with relu on.
- Address: output_channel=16 (OG=2), IG=1, out_ch_sel 0,8,0,8 -> addrs 0,1,2,3; pixel_done only on addrs 1 and 3.
- Sequence error: beat with in_ch_sel=8 in IDLE -> seq_err=1, no write. Subsequent valid group -> normal write, seq_err stays 1.
- Reset asserted between group beats 2 and 3 of IG=4 -> no write, outputs 0. A full group afterwards accumulates from zero correctly.

Source files
------------

// File: rtl/point_out_writeback.sv
// point_out_writeback: accumulates 8-lane pointwise partial sums over input-channel groups,
// requantizes them and writes one 8-lane word per (pixel, output-channel group).
module point_out_writeback #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH*LANES-1:0]   in_feature,
    input  logic [7:0]                    in_ch_sel,
    input  logic [7:0]                    out_ch_sel,
    input  logic [7:0]                    input_channel,
    input  logic [7:0]                    output_channel,
    input  logic [7:0]                    output_size,
    input  logic                          relu_en,
    input  logic [3:0]                    quant_shift,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH*LANES-1:0]   wr_data,
    output logic                          pixel_done,
    output logic                          layer_done,
    output logic                          seq_err
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MINV = ACC_WIDTH'(-(2**(DATA_WIDTH-1)));

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q [LANES];
    logic signed [ACC_WIDTH-1:0]  acc_d [LANES];
    logic signed [ACC_WIDTH-1:0]  fin_q [LANES];
    logic signed [ACC_WIDTH-1:0]  fin_d [LANES];
    logic signed [ACC_WIDTH-1:0]  sum   [LANES];
    logic signed [ACC_WIDTH-1:0]  shv   [LANES];
    logic signed [ACC_WIDTH-1:0]  rlv   [LANES];
    logic [4:0]                   ig_q, og_q, ig, og, ocg_q, ocg_d;
    logic [15:0]                  npix_q, npix, pix_q, pix_d;
    logic [7:0]                   prev_q, prev_d;
    logic                         fin_v_q, fin_v_d, err_d;
    logic                         idle, beat, last, last_grp, last_pix;
    logic [31:0]                  addr_full;
    logic [DATA_WIDTH*LANES-1:0]  wdata;
    logic                         unused;

    assign unused = ^out_ch_sel[2:0];

    // Configuration follows the inputs while idle and is frozen during a group.
    always_comb begin
        idle = state_q == IDLE;
        ig   = idle ? (input_channel < 8'd8 ? 5'd1 : input_channel[7:3]) : ig_q;
        og   = idle ? (output_channel < 8'd8 ? 5'd1 : output_channel[7:3]) : og_q;
        npix = idle ? 16'(output_size) * 16'(output_size) : npix_q;
        beat = in_valid && (!idle || in_ch_sel == 8'd0);
        last = beat && in_ch_sel == {ig - 5'd1, 3'b000};
        for (int k = 0; k < LANES; k++) begin
            sum[k]   = (in_ch_sel == 8'd0 ? '0 : acc_q[k])
                     + ACC_WIDTH'($signed(in_feature[k*DATA_WIDTH +: DATA_WIDTH]));
            acc_d[k] = beat ? sum[k] : acc_q[k];
            fin_d[k] = last ? sum[k] : fin_q[k];
        end
        state_d = beat ? (last ? IDLE : ACCUM) : state_q;
        prev_d  = beat ? in_ch_sel : prev_q;
        err_d   = seq_err | (in_valid && in_ch_sel != 8'd0 && (idle || in_ch_sel != prev_q + 8'd8));
        fin_v_d = last;
        ocg_d   = last ? out_ch_sel[7:3] : ocg_q;
    end

    always_comb begin
        wdata = '0;
        for (int k = 0; k < LANES; k++) begin
            shv[k] = fin_q[k] >>> quant_shift;
            rlv[k] = (relu_en && shv[k] < 0) ? '0 : shv[k];
            wdata[k*DATA_WIDTH +: DATA_WIDTH] = rlv[k] > MAXV ? MAXV[DATA_WIDTH-1:0] :
                                                rlv[k] < MINV ? MINV[DATA_WIDTH-1:0] :
                                                rlv[k][DATA_WIDTH-1:0];
        end
        addr_full = 32'(pix_q) * 32'(og) + 32'(ocg_q);
        last_grp  = fin_v_q && ocg_q == og - 5'd1;
        last_pix  = last_grp && pix_q == npix - 16'd1;
        pix_d     = last_grp ? (last_pix ? 16'd0 : pix_q + 16'd1) : pix_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ig_q       <= 5'd1;
            og_q       <= 5'd1;
            npix_q     <= '0;
            pix_q      <= '0;
            prev_q     <= '0;
            ocg_q      <= '0;
            fin_v_q    <= 1'b0;
            seq_err    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pixel_done <= 1'b0;
            layer_done <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= '0;
                fin_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ig_q       <= ig;
            og_q       <= og;
            npix_q     <= npix;
            pix_q      <= pix_d;
            prev_q     <= prev_d;
            ocg_q      <= ocg_d;
            fin_v_q    <= fin_v_d;
            seq_err    <= err_d;
            wr_en      <= fin_v_q;
            wr_addr    <= addr_full[ADDR_WIDTH-1:0];
            wr_data    <= wdata;
            pixel_done <= last_grp;
            layer_done <= last_pix;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= acc_d[k];
                fin_q[k] <= fin_d[k];
            end
        end
    end
endmodule
